// File: rtl/image_mem_arbiter.sv
// image_mem_arbiter: shares the image memory port between the processor (P0)
// and the frame-readout DMA (P1). Per-cycle round-robin with a combinational
// grant, a one-cycle tagged read return and a saturating contention counter.
// Optional burst lock for the DMA when IMG_ARB_BURST_EN is defined.
module image_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  input  logic          p1_lock,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] contention_cnt,
  output logic          busy
);

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

`ifdef IMG_ARB_BURST_EN
  typedef enum logic {ARB, P1_BURST} state_t;
  localparam int BCW = $clog2(MAX_BURST + 1);
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
`else
  typedef enum logic {ARB} state_t;
  logic unused_lock;
  assign unused_lock = p1_lock;
`endif

  state_t        state_q, state_d;
  logic          last_winner_q, last_winner_d;
  logic          pend_vld_q, pend_vld_d;
  logic          pend_tag_q, pend_tag_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Grant decision: round-robin on ties, DMA priority while a burst is held.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
`ifdef IMG_ARB_BURST_EN
      if (state_q == P1_BURST) begin
        p1_gnt = p1_req;
        p0_gnt = p0_req & ~p1_req;
      end else
`endif
      if (p0_req && p1_req) begin
        if (last_winner_q == P1) p0_gnt = 1'b1;
        else                     p1_gnt = 1'b1;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  // FSM next state and last-winner tracking.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    if (p0_gnt) last_winner_d = P0;
    if (p1_gnt) last_winner_d = P1;
`ifdef IMG_ARB_BURST_EN
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB: begin
        // A burst of length one would end on entry, so stay in ARB then.
        if (p1_gnt && p1_lock && MAX_BURST > 1) begin
          state_d     = P1_BURST;
          burst_cnt_d = BCW'(1);
        end
      end
      default: begin
        if (p1_gnt) burst_cnt_d = burst_cnt_q + BCW'(1);
        if (!p1_lock || (p1_gnt && (burst_cnt_q + BCW'(1)) >= BCW'(MAX_BURST))) begin
          state_d       = ARB;
          last_winner_d = P1;
        end
      end
    endcase
`endif
  end

  // Memory drive from the winner; address/data hold when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (p0_gnt) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
  end

  // Read return: tag the granted read, steer mem_rdata to its owner next cycle.
  always_comb begin
    pend_vld_d = (p0_gnt | p1_gnt) & ~mem_we;
    pend_tag_d = p1_gnt;
    p0_rvalid  = pend_vld_q & (pend_tag_q == P0);
    p1_rvalid  = pend_vld_q & (pend_tag_q == P1);
    p0_rdata   = p0_rvalid ? mem_rdata : p0_rdata_q;
    p1_rdata   = p1_rvalid ? mem_rdata : p1_rdata_q;
    p0_rdata_d = p0_rdata;
    p1_rdata_d = p1_rdata;
  end

  // Saturating contention counter and busy flag.
  always_comb begin
    cnt_d = cnt_q;
    if (p0_req && p1_req && cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
    contention_cnt = cnt_q;
    busy           = p0_gnt | p1_gnt | pend_vld_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB;
      last_winner_q <= P1;
      pend_vld_q    <= 1'b0;
      pend_tag_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
      cnt_q         <= '0;
`ifdef IMG_ARB_BURST_EN
      burst_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      pend_vld_q    <= pend_vld_d;
      pend_tag_q    <= pend_tag_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
      cnt_q         <= cnt_d;
`ifdef IMG_ARB_BURST_EN
      burst_cnt_q   <= burst_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Scoreboard bench for image_mem_arbiter: directed stimulus pushes expected
// read returns, a negedge monitor pops and checks them. Includes a write-first
// synchronous memory model behind the arbiter.
module tb_image_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, p1_lock = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_we, busy;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] contention_cnt;

  image_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_lock(p1_lock),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .contention_cnt(contention_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Image memory model: synchronous read, write-first.
  logic [DW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 1);
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : mem[mem_addr[7:0]];
  end

  int n_chk = 0;
  int n_pass = 0;

  typedef struct { bit port; logic [DW-1:0] data; } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Preloaded contents, except address 0x10 which the bench overwrites with 0xAB.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return (a == 32'h10) ? 8'hAB : 8'(a[7:0] * 3 + 1);
  endfunction

  // Monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (!rst && (p0_rvalid || p1_rvalid)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rvalid_port", {p0_rvalid, p1_rvalid}, e.port ? 2'b01 : 2'b10);
        chk("rdata", e.port ? p1_rdata : p0_rdata, e.data);
      end
    end
  end

  // One cycle of stimulus with expected grants; granted reads go to the scoreboard.
  task automatic step(input bit r0, input bit w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input bit r1, input logic [AW-1:0] a1,
                      input bit eg0, input bit eg1, input string nm);
    exp_t e;
    @(posedge clk); #1;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = 1'b0; p1_addr = a1;
    #1;
    chk({nm, "_g0"}, p0_gnt, eg0);
    chk({nm, "_g1"}, p1_gnt, eg1);
    if (eg0 && !w0) begin e.port = 1'b0; e.data = exp_rd(a0); sbq.push_back(e); end
    if (eg1)        begin e.port = 1'b1; e.data = exp_rd(a1); sbq.push_back(e); end
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0, 0, 0, "idle");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; p0_req = 0; p1_req = 0;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("reset_outs", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we, busy, mem_addr,
                       mem_wdata, p0_rdata, p1_rdata, contention_cnt}, '0);

    // Write then read back through P0.
    step(1, 1, 32'h10, 8'hAB, 0, '0, 1, 0, "wr");
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h10);
    chk("wr_mem_wdata", mem_wdata, 8'hAB);
    step(1, 0, 32'h10, '0, 0, '0, 1, 0, "rd");
    chk("rd_mem_we", mem_we, 0);
    idle();
    chk("idle_addr_hold", mem_addr, 32'h10);
    chk("idle_we", mem_we, 0);

    // Continuous contention: strict alternation starting with P0.
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1, 0, 32'h20 + i, '0, 1, 32'h30 + i, (i % 2) == 0, (i % 2) == 1, "alt");
    idle();
    chk("cont_cnt6", contention_cnt, 6);
    chk("busy_pending", busy, 1);
    idle();
    chk("busy_clear", busy, 0);

    // P1 back-to-back reads; P0 rdata must hold its last value.
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1, i, 0, 1, "p1seq");
    idle();
    idle();
    chk("p0_rdata_hold", p0_rdata, exp_rd(32'h24));
    chk("p1_rdata_last", p1_rdata, exp_rd(32'h3));

    // Reset during an outstanding P0 read: the return is dropped.
    step(1, 0, 32'h40, '0, 0, '0, 1, 0, "rst_rd");
    #1;
    rst = 1'b1; p0_req = 0; p1_req = 0;
    sbq.delete();
    #1;
    chk("mid_rst_outs", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we, busy, mem_addr,
                         mem_wdata, p0_rdata, p1_rdata, contention_cnt}, '0);
    @(posedge clk); #1;
    chk("rst_no_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
    rst = 1'b0;
    step(1, 0, 32'h50, '0, 1, 32'h51, 1, 0, "tie_after_rst");

    // 21 contended cycles in total: counter saturates at 15.
    for (int i = 0; i < 20; i++)
      step(1, 0, i, '0, 1, i + 100, (i % 2) == 1, (i % 2) == 0, "sat");
    idle();
    chk("cont_sat", contention_cnt, 15);

`ifdef IMG_ARB_BURST_EN
    // Burst lock: first tie to P0, then P1 holds for MB grants, then P0.
    do_reset();
    p1_lock = 1'b1;
    step(1, 0, 32'h60, '0, 1, 32'h70, 1, 0, "burst");
    for (int i = 0; i < MB; i++) step(1, 0, 32'h60, '0, 1, 32'h71 + i, 0, 1, "burst");
    step(1, 0, 32'h61, '0, 1, 32'h78, 1, 0, "burst_exit");
    step(1, 0, 32'h62, '0, 1, 32'h79, 0, 1, "burst_alt");
    p1_lock = 1'b0;
    idle();
`endif

    idle();
    idle();
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
